// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the streaming 3x3 convolution engine.
package conv_pkg;

  localparam int PAD_VALID = 0;
  localparam int PAD_SAME  = 1;

  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 6;
  endfunction

  function automatic int tap_idx(input int ky, input int kx);
    return ky * 3 + kx;
  endfunction

  // Clamp a signed value into the signed range of an out_w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] val, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi) begin
      res = hi;
    end else if (val < lo) begin
      res = lo;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two row buffers indexed by column; a write pushes the old middle value up to the top row.
module conv_line_buffer #(
  parameter int DEPTH  = 30,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] mid
);

  logic [DATA_W-1:0] row0_r [DEPTH];
  logic [DATA_W-1:0] row1_r [DEPTH];

  assign top = row1_r[idx];
  assign mid = row0_r[idx];

  // Row storage is pure datapath and deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      row1_r[idx] <= row0_r[idx];
      row0_r[idx] <= din;
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 3x3 convolution: one raster-order pixel in, one saturated result out per step,
// with optional zero padding (same mode) and ReLU.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = acc_width(DATA_W, COEF_W),
  parameter int PAD_MODE = PAD_SAME,
  parameter int RELU     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [9*COEF_W-1:0] kernel,
  input  logic [BIAS_W-1:0]   bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int VW = IMG_W + 2 * PAD_MODE;
  localparam int VH = IMG_H + 2 * PAD_MODE;
  localparam int CW = $clog2(VW);
  localparam int RW = $clog2(VH);
  localparam logic [CW-1:0] VC_LAST = CW'(VW - 1);
  localparam logic [RW-1:0] VR_LAST = RW'(VH - 1);

  logic [RW-1:0]              vr_r;
  logic [CW-1:0]              vc_r;
  logic                       out_valid_r;
  logic                       out_last_r;
  logic [OUT_W-1:0]           out_data_r;
  logic signed [COEF_W-1:0]   kern_r [9];
  logic signed [BIAS_W-1:0]   bias_r;
  logic [DATA_W-1:0]          win_r [3][3];

  logic                       border_s;
  logic                       step_en_s;
  logic                       step_s;
  logic                       produce_s;
  logic                       first_s;
  logic                       last_pos_s;
  logic [DATA_W-1:0]          pix_s;
  logic [DATA_W-1:0]          col_top_s;
  logic [DATA_W-1:0]          col_mid_s;
  logic [DATA_W-1:0]          win_s [3][3];
  logic signed [ACC_W-1:0]    acc_s;
  logic signed [ACC_W-1:0]    relu_s;

  conv_line_buffer #(
    .DEPTH (VW),
    .DATA_W(DATA_W),
    .IDX_W (CW)
  ) u_line_buffer (
    .clk  (clk),
    .wr_en(step_s),
    .idx  (vc_r),
    .din  (pix_s),
    .top  (col_top_s),
    .mid  (col_mid_s)
  );

  // Position decode and handshake: border positions inject a zero and consume nothing.
  always_comb begin
    border_s = 1'b0;
    if (PAD_MODE == PAD_SAME) begin
      border_s = (vr_r == RW'(0)) || (vr_r == VR_LAST) || (vc_r == CW'(0)) || (vc_r == VC_LAST);
    end else begin
      border_s = 1'b0;
    end
    step_en_s  = !out_valid_r || out_ready;
    in_ready   = step_en_s && !border_s;
    step_s     = step_en_s && (border_s || in_valid);
    produce_s  = (vr_r >= RW'(2)) && (vc_r >= CW'(2));
    first_s    = (vr_r == RW'(0)) && (vc_r == CW'(0));
    last_pos_s = (vr_r == VR_LAST) && (vc_r == VC_LAST);
    if (border_s) begin
      pix_s = {DATA_W{1'b0}};
    end else begin
      pix_s = in_data;
    end
  end

  // Post-shift window and its multiply-accumulate against the latched kernel.
  always_comb begin
    for (int ky = 0; ky < 3; ky++) begin
      win_s[ky][0] = win_r[ky][1];
      win_s[ky][1] = win_r[ky][2];
    end
    win_s[0][2] = col_top_s;
    win_s[1][2] = col_mid_s;
    win_s[2][2] = pix_s;
    acc_s = ACC_W'(bias_r);
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        acc_s = acc_s + ACC_W'($signed({1'b0, win_s[ky][kx]})) * ACC_W'(kern_r[tap_idx(ky, kx)]);
      end
    end
    if ((RELU == 1) && acc_s[ACC_W-1]) begin
      relu_s = {ACC_W{1'b0}};
    end else begin
      relu_s = acc_s;
    end
  end

  // Frame position, configuration latch, window state and registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vr_r        <= RW'(0);
      vc_r        <= CW'(0);
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      bias_r      <= {BIAS_W{1'b0}};
      for (int k = 0; k < 9; k++) begin
        kern_r[k] <= {COEF_W{1'b0}};
      end
      for (int ky = 0; ky < 3; ky++) begin
        for (int kx = 0; kx < 3; kx++) begin
          win_r[ky][kx] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      if (step_s) begin
        win_r <= win_s;
        if (vc_r == VC_LAST) begin
          vc_r <= CW'(0);
          if (vr_r == VR_LAST) begin
            vr_r <= RW'(0);
          end else begin
            vr_r <= vr_r + RW'(1);
          end
        end else begin
          vc_r <= vc_r + CW'(1);
        end
        if (first_s) begin
          bias_r <= bias;
          for (int k = 0; k < 9; k++) begin
            kern_r[k] <= kernel[k*COEF_W +: COEF_W];
          end
        end
      end
      if (step_s && produce_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= last_pos_s;
        out_data_r  <= OUT_W'(sat(64'(relu_s), OUT_W));
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = (vr_r != RW'(0)) || (vc_r != CW'(0)) || out_valid_r;

endmodule

// File: tb/tb_conv2d_stream.sv
// Scoreboard bench: three 4x4 instances (same/16-bit, valid/8-bit, valid/8-bit+ReLU) against a direct convolution model.
module tb_conv2d_stream;

  typedef int img_t [16];
  typedef int kern_t [9];
  typedef struct {
    int inst;
    int val;
    bit last;
  } exp_t;

  localparam int PAD_OF  [3] = '{1, 0, 0};
  localparam int OW_OF   [3] = '{16, 8, 8};
  localparam int RELU_OF [3] = '{0, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ordy;
  logic [7:0]  din;
  logic [71:0] kern_bus;
  logic [15:0] bias_bus;
  logic        iv [3];
  logic        irdy [3];
  logic        ov [3];
  logic        ol [3];
  logic        bz [3];
  logic signed [15:0] od0;
  logic signed [7:0]  od1;
  logic signed [7:0]  od2;
  int          od [3];

  kern_t cur_k;
  int    cur_b;
  exp_t  exp_q [$];
  int    total = 0;
  int    bad = 0;
  bit    rnd_mode = 1'b0;
  bit    prev_stall [3];
  int    prev_data [3];
  int    prev_last [3];

  conv2d_stream #(.IMG_W(4), .IMG_H(4), .OUT_W(16), .PAD_MODE(1), .RELU(0)) dut_same (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(din),
    .kernel(kern_bus), .bias(bias_bus), .out_valid(ov[0]), .out_ready(ordy),
    .out_data(od0), .out_last(ol[0]), .busy(bz[0]));

  conv2d_stream #(.IMG_W(4), .IMG_H(4), .OUT_W(8), .PAD_MODE(0), .RELU(0)) dut_valid (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(din),
    .kernel(kern_bus), .bias(bias_bus), .out_valid(ov[1]), .out_ready(ordy),
    .out_data(od1), .out_last(ol[1]), .busy(bz[1]));

  conv2d_stream #(.IMG_W(4), .IMG_H(4), .OUT_W(8), .PAD_MODE(0), .RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(din),
    .kernel(kern_bus), .bias(bias_bus), .out_valid(ov[2]), .out_ready(ordy),
    .out_data(od2), .out_last(ol[2]), .busy(bz[2]));

  always_comb begin
    od[0] = int'(od0);
    od[1] = int'(od1);
    od[2] = int'(od2);
    kern_bus = 72'd0;
    for (int k = 0; k < 9; k++) kern_bus[k*8 +: 8] = 8'(cur_k[k]);
    bias_bus = 16'(cur_b);
  end

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: direct 3x3 convolution over the image with zero padding outside it.
  task automatic push_frame(input int inst, input img_t p, input kern_t k, input int b);
    int n_o, off, s, y, x, hi, lo;
    exp_t e;
    n_o = (PAD_OF[inst] != 0) ? 4 : 2;
    off = (PAD_OF[inst] != 0) ? -1 : 0;
    hi = (1 << (OW_OF[inst] - 1)) - 1;
    lo = -(1 << (OW_OF[inst] - 1));
    for (int r = 0; r < n_o; r++) begin
      for (int c = 0; c < n_o; c++) begin
        s = b;
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            y = r + ky + off;
            x = c + kx + off;
            if (y >= 0 && y < 4 && x >= 0 && x < 4) s += p[y*4 + x] * k[ky*3 + kx];
          end
        end
        if (RELU_OF[inst] != 0 && s < 0) s = 0;
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
        e.inst = inst;
        e.val  = s;
        e.last = (r == n_o - 1) && (c == n_o - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Offer 16 pixels; the next frame's config is applied mid-frame. abort_after>0 stops early.
  task automatic send_frame(input int inst, input img_t p, input bit gaps, input kern_t nk,
                            input int nb, input int abort_after);
    int t;
    bit acc;
    for (int n = 0; n < 16; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          iv[inst] = 1'b0;
        end
      end
      t = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        iv[inst] = 1'b1;
        din = 8'(p[n]);
        #1;
        acc = irdy[inst];
        @(posedge clk);
        #1;
        t++;
        if (!acc && t > 200) begin
          total++;
          bad++;
          $display("FAIL accept_timeout: inst %0d pixel %0d never accepted", inst, n);
          iv[inst] = 1'b0;
          return;
        end
      end
      if (n == 8) begin
        cur_k = nk;
        cur_b = nb;
      end
      if (n + 1 == abort_after) begin
        iv[inst] = 1'b0;
        return;
      end
    end
    @(negedge clk);
    iv[inst] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    ordy = 1'b1;
    forever begin
      @(negedge clk);
      ordy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: consume handshakes, check stall stability and in_ready during stalls.
  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          prev_stall[i] = 1'b0;
        end else begin
          if (prev_stall[i]) begin
            check("stall_hold_valid", int'(ov[i]), 1);
            check("stall_hold_data", od[i], prev_data[i]);
            check("stall_hold_last", int'(ol[i]), prev_last[i]);
          end
          if (ov[i] && ordy) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_output: inst %0d data %0d, expected none", i, od[i]);
            end else begin
              e = exp_q.pop_front();
              check("out_inst", i, e.inst);
              check("out_data", od[i], e.val);
              check("out_last", int'(ol[i]), int'(e.last));
            end
          end
          if (ov[i] && !ordy) begin
            check("stall_in_ready", int'(irdy[i]), 0);
            prev_stall[i] = 1'b1;
            prev_data[i]  = od[i];
            prev_last[i]  = int'(ol[i]);
          end else begin
            prev_stall[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    img_t ramp, ones_img, full;
    kern_t k_id, k_one, k_127, k_m128;
    for (int i = 0; i < 16; i++) begin
      ramp[i] = i;
      ones_img[i] = 1;
      full[i] = 255;
    end
    for (int i = 0; i < 9; i++) begin
      k_id[i] = (i == 4) ? 1 : 0;
      k_one[i] = 1;
      k_127[i] = 127;
      k_m128[i] = -128;
    end
    rst_n = 1'b0;
    din = 8'd0;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    cur_k = k_id;
    cur_b = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_valid", int'(ov[i]), 0);
      check("reset_last", int'(ol[i]), 0);
      check("reset_busy", int'(bz[i]), 0);
      check("reset_data", od[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Same mode identity, then all-ones with a mid-frame bias change.
    push_frame(0, ramp, k_id, 0);
    send_frame(0, ramp, 1'b0, k_one, 0, 0);
    drain();
    push_frame(0, ones_img, k_one, 0);
    send_frame(0, ones_img, 1'b0, k_one, -9, 0);
    drain();
    push_frame(0, ones_img, k_one, -9);
    send_frame(0, ones_img, 1'b0, k_id, 0, 0);
    drain();

    // Random backpressure and input gaps.
    rnd_mode = 1'b1;
    push_frame(0, ramp, k_id, 0);
    send_frame(0, ramp, 1'b1, k_id, 0, 0);
    drain();
    rnd_mode = 1'b0;

    // Asynchronous reset after 7 accepted pixels.
    push_frame(0, ramp, k_id, 0);
    send_frame(0, ramp, 1'b0, k_id, 0, 7);
    check("pre_reset_busy", int'(bz[0]), 1);
    check("pre_reset_valid", int'(ov[0]), 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_valid", int'(ov[0]), 0);
    check("async_reset_last", int'(ol[0]), 0);
    check("async_reset_busy", int'(bz[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(0, ramp, k_id, 0);
    send_frame(0, ramp, 1'b0, k_one, 0, 0);
    drain();

    // Valid mode and saturation / ReLU on 8-bit outputs.
    push_frame(1, ramp, k_one, 0);
    send_frame(1, ramp, 1'b0, k_127, 0, 0);
    drain();
    push_frame(1, full, k_127, 0);
    send_frame(1, full, 1'b0, k_m128, 0, 0);
    drain();
    push_frame(1, full, k_m128, 0);
    send_frame(1, full, 1'b0, k_m128, 0, 0);
    drain();
    push_frame(2, full, k_m128, 0);
    send_frame(2, full, 1'b0, k_id, 0, 0);
    drain();

    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
